iob_ram_2p_be_init: RTL and testbench

Simple dual-port RAM: one write port, one read port, one clock. Write-side column (byte) enables with configurable column width. Read latency of 1 or 2 cycles, with a read-valid flag. After every reset, a hardware init sweep zeroes the whole array. Generalises the single-port byte-enable RAM for use as register-file, FIFO and buffer storage in IOb peripherals.

---
 rtl/iob_ram_2p_be_init_pkg.sv | 15 +
 rtl/iob_ram_2p_be_mem.sv | 45 ++++
 rtl/iob_ram_2p_be_init.sv | 169 ++++++++++++++++
 tb/tb_iob_ram_2p_be_init.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_ram_2p_be_init_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iob_ram_2p_be_init_pkg
//  Purpose  : Shared constants for the byte-enable dual-port RAM with init
//             sweep: FSM state encodings.
//  Revision : 1.0  initial release
// ============================================================================
package iob_ram_2p_be_init_pkg;

  // Controller states: sweeping zeros into the array, then normal operation.
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage : iob_ram_2p_be_init_pkg
`default_nettype wire

// File: rtl/iob_ram_2p_be_mem.sv
`default_nettype none
// ============================================================================
//  Module   : iob_ram_2p_be_mem
//  Purpose  : Bare simple dual-port array. One write port with per-column
//             enables, one synchronous read port. No reset, so it maps onto
//             block RAM. Read and write to the same address in the same
//             cycle return the old contents (read-first).
//  Revision : 1.0  initial release
// ============================================================================
module iob_ram_2p_be_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int COL_W  = 8
) (
  input  logic                     clk_i,
  input  logic [DATA_W/COL_W-1:0]  w_en_i,
  input  logic [ADDR_W-1:0]        w_addr_i,
  input  logic [DATA_W-1:0]        w_data_i,
  input  logic                     r_en_i,
  input  logic [ADDR_W-1:0]        r_addr_i,
  output logic [DATA_W-1:0]        r_data_o
);

  localparam int N_COL = DATA_W / COL_W;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Column-granular write: only enabled columns of the addressed word change.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < N_COL; c++) begin
      if (w_en_i[c]) begin
        mem[w_addr_i][c*COL_W +: COL_W] <= w_data_i[c*COL_W +: COL_W];
      end
    end
  end

  // Synchronous read; output holds while no read is issued.
  always_ff @(posedge clk_i) begin
    if (r_en_i) begin
      r_data_o <= mem[r_addr_i];
    end
  end

endmodule : iob_ram_2p_be_mem
`default_nettype wire

// File: rtl/iob_ram_2p_be_init.sv
`default_nettype none
// ============================================================================
//  Module   : iob_ram_2p_be_init
//  Purpose  : Simple dual-port RAM with per-column write enables, 1- or
//             2-cycle read latency with a valid pulse, and a hardware sweep
//             that zeroes the whole array after every reset.
//  Options  : IOB_RAM_2P_BE_INIT_BYPASS_EN -- when defined, a same-address
//             same-cycle read/write returns the merged (write-first) word;
//             otherwise collisions are read-first.
//  Revision : 1.0  initial release
// ============================================================================
module iob_ram_2p_be_init
  import iob_ram_2p_be_init_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int COL_W    = 8,
  parameter int READ_LAT = 1
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  output logic                     busy_o,
  input  logic                     w_en_i,
  input  logic [DATA_W/COL_W-1:0]  w_strb_i,
  input  logic [ADDR_W-1:0]        w_addr_i,
  input  logic [DATA_W-1:0]        w_data_i,
  input  logic                     r_en_i,
  input  logic [ADDR_W-1:0]        r_addr_i,
  output logic [DATA_W-1:0]        r_data_o,
  output logic                     r_valid_o
);

  localparam int              N_COL    = DATA_W / COL_W;
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  // Parameter legality, caught at elaboration.
  if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_read_lat
    $error("iob_ram_2p_be_init: READ_LAT must be 1 or 2");
  end
  if ((DATA_W % COL_W) != 0) begin : g_bad_col_w
    $error("iob_ram_2p_be_init: DATA_W must be a multiple of COL_W");
  end

  logic [0:0]        state;
  logic [ADDR_W:0]   cnt;     // one extra bit so the end of the sweep never aliases
  logic              run;

  logic [N_COL-1:0]  mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] merged;

  logic              v1;      // a read was issued at the previous edge
  logic [DATA_W-1:0] hold;    // last completed read word

  assign run    = (state == ST_RUN);
  assign busy_o = ~run;

  // Init sweep controller: one zero write per cycle, then RUN until reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST_CNT) begin
        state <= ST_RUN;
      end
    end
  end

  // Write port is owned by the sweep while busy; user requests are dropped.
  always_comb begin
    mem_we    = '1;
    mem_waddr = cnt[ADDR_W-1:0];
    mem_wdata = '0;
    if (run) begin
      mem_we    = w_en_i ? w_strb_i : '0;
      mem_waddr = w_addr_i;
      mem_wdata = w_data_i;
    end
  end

  assign mem_re = run & r_en_i;

  iob_ram_2p_be_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W)
  ) u_mem (
    .clk_i    (clk_i),
    .w_en_i   (mem_we),
    .w_addr_i (mem_waddr),
    .w_data_i (mem_wdata),
    .r_en_i   (mem_re),
    .r_addr_i (r_addr_i),
    .r_data_o (mem_rdata)
  );

`ifdef IOB_RAM_2P_BE_INIT_BYPASS_EN
  logic [N_COL-1:0]  byp_strb;
  logic [DATA_W-1:0] byp_data;

  // Capture which columns of the word being read were overwritten this edge.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      byp_strb <= '0;
      byp_data <= '0;
    end else if (mem_re) begin
      byp_strb <= (w_en_i && (w_addr_i == r_addr_i)) ? w_strb_i : '0;
      byp_data <= w_data_i;
    end
  end

  // Per-column merge of new write data over the old array word.
  always_comb begin
    merged = mem_rdata;
    for (int c = 0; c < N_COL; c++) begin
      if (byp_strb[c]) begin
        merged[c*COL_W +: COL_W] = byp_data[c*COL_W +: COL_W];
      end
    end
  end
`else
  assign merged = mem_rdata;
`endif

  // First read-pipeline stage: flags array output as fresh.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      v1 <= 1'b0;
    end else begin
      v1 <= mem_re;
    end
  end

  // Keeps the last delivered word so r_data_o holds between reads.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      hold <= '0;
    end else if (v1) begin
      hold <= merged;
    end
  end

  if (READ_LAT == 1) begin : g_lat1
    assign r_valid_o = v1;
    assign r_data_o  = v1 ? merged : hold;
  end else begin : g_lat2
    logic v2;

    // Second stage: valid follows the registered output word.
    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
        v2 <= 1'b0;
      end else begin
        v2 <= v1;
      end
    end

    assign r_valid_o = v2;
    assign r_data_o  = hold;
  end

endmodule : iob_ram_2p_be_init
`default_nettype wire

// File: tb/tb_iob_ram_2p_be_init.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_iob_ram_2p_be_init
//  Purpose  : Self-checking bench. Two instances (READ_LAT=1 and 2) share the
//             same stimulus and are compared against a word-array reference
//             model. Honours IOB_RAM_2P_BE_INIT_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iob_ram_2p_be_init;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int COL_W  = 8;
  localparam int N_COL  = DATA_W / COL_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic              w_en = 1'b0;
  logic [N_COL-1:0]  w_strb = '0;
  logic [ADDR_W-1:0] w_addr = '0;
  logic [DATA_W-1:0] w_data = '0;
  logic              r_en = 1'b0;
  logic [ADDR_W-1:0] r_addr = '0;

  logic              busy1, busy2, rv1, rv2;
  logic [DATA_W-1:0] rd1, rd2;

  always #5 clk = ~clk;

  iob_ram_2p_be_init #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .COL_W(COL_W), .READ_LAT(1)) u_dut1 (
    .clk_i(clk), .arst_i(arst), .busy_o(busy1),
    .w_en_i(w_en), .w_strb_i(w_strb), .w_addr_i(w_addr), .w_data_i(w_data),
    .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(rd1), .r_valid_o(rv1)
  );

  iob_ram_2p_be_init #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .COL_W(COL_W), .READ_LAT(2)) u_dut2 (
    .clk_i(clk), .arst_i(arst), .busy_o(busy2),
    .w_en_i(w_en), .w_strb_i(w_strb), .w_addr_i(w_addr), .w_data_i(w_data),
    .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(rd2), .r_valid_o(rv2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int due; logic [DATA_W-1:0] data;} rd_t;

  logic [DATA_W-1:0] mem_m [DEPTH];
  int                init_left;
  int                cyc = 0;
  rd_t               q1[$];
  rd_t               q2[$];
  logic [DATA_W-1:0] last1, last2;

  task automatic model_reset();
    init_left = DEPTH;
    q1.delete();
    q2.delete();
    last1 = '0;
    last2 = '0;
    for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge,
  // then compare both instances.
  task automatic model_edge_and_check();
    logic [DATA_W-1:0] d;
    logic              exp_v1, exp_v2;
    cyc++;
    if (init_left > 0) begin
      init_left--;
    end else begin
      if (r_en) begin
        d = mem_m[r_addr];
`ifdef IOB_RAM_2P_BE_INIT_BYPASS_EN
        if (w_en && (w_addr == r_addr))
          for (int c = 0; c < N_COL; c++)
            if (w_strb[c]) d[c*COL_W +: COL_W] = w_data[c*COL_W +: COL_W];
`endif
        q1.push_back('{due: cyc,     data: d});
        q2.push_back('{due: cyc + 1, data: d});
      end
      if (w_en)
        for (int c = 0; c < N_COL; c++)
          if (w_strb[c]) mem_m[w_addr][c*COL_W +: COL_W] = w_data[c*COL_W +: COL_W];
    end
    exp_v1 = (q1.size() > 0) && (q1[0].due == cyc);
    exp_v2 = (q2.size() > 0) && (q2[0].due == cyc);
    if (exp_v1) last1 = q1.pop_front().data;
    if (exp_v2) last2 = q2.pop_front().data;
    check("busy_lat1",  {31'd0, busy1}, {31'd0, init_left > 0});
    check("busy_lat2",  {31'd0, busy2}, {31'd0, init_left > 0});
    check("valid_lat1", {31'd0, rv1},   {31'd0, exp_v1});
    check("valid_lat2", {31'd0, rv2},   {31'd0, exp_v2});
    check("data_lat1",  rd1, last1);
    check("data_lat2",  rd2, last2);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge_and_check();
  endtask

  task automatic idle();
    w_en = 1'b0; r_en = 1'b0; w_strb = '0;
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d, input logic [N_COL-1:0] s);
    w_en = 1'b1; w_addr = ADDR_W'(a); w_data = d; w_strb = s;
  endtask

  task automatic rdreq(input int a);
    r_en = 1'b1; r_addr = ADDR_W'(a);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy1"},  {31'd0, busy1}, 32'd1);
    check({tag, "_busy2"},  {31'd0, busy2}, 32'd1);
    check({tag, "_valid1"}, {31'd0, rv1},   32'd0);
    check({tag, "_valid2"}, {31'd0, rv2},   32'd0);
    check({tag, "_data1"},  rd1, '0);
    check({tag, "_data2"},  rd2, '0);
  endtask

  logic [DATA_W-1:0] coll_exp;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check_reset_outputs("reset");
    arst = 1'b0;

    // Requests during the sweep must be dropped (addr 5 must stay zero).
    for (int i = 0; i < DEPTH; i++) begin
      wr(5, 32'hDEADBEEF, '1);
      rdreq(i);
      step();
    end
    idle();

    // Every address reads zero after the sweep, back to back.
    for (int i = 0; i < DEPTH; i++) begin
      rdreq(i);
      step();
    end
    idle(); step(); step();

    // Column strobes.
    wr(3, 32'hAABBCCDD, 4'b1111); step();
    wr(3, 32'h11223344, 4'b0101); step();
    idle(); rdreq(3); step();
    check("strb_lat1", rd1, 32'hAA22CC44);
    idle(); step();
    check("strb_lat2", rd2, 32'hAA22CC44);

    // Fill with i+32, then stream reads across the whole array.
    for (int i = 0; i < DEPTH; i++) begin
      wr(i, DATA_W'(i + 32), '1);
      step();
    end
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      rdreq(i);
      step();
    end
    idle(); step(); step();

    // Same-address collision.
    wr(7, 32'h01020304, '1); step();
    wr(7, 32'hFFFFFFFF, 4'b0011); rdreq(7); step();
`ifdef IOB_RAM_2P_BE_INIT_BYPASS_EN
    coll_exp = 32'h0102FFFF;
`else
    coll_exp = 32'h01020304;
`endif
    check("collision_lat1", rd1, coll_exp);
    idle(); step();
    check("collision_lat2", rd2, coll_exp);
    step();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      w_en   = ($urandom_range(0, 3) != 0);
      w_strb = N_COL'($urandom);
      w_addr = ADDR_W'($urandom);
      w_data = $urandom;
      r_en   = ($urandom_range(0, 3) != 0);
      r_addr = ($urandom_range(0, 4) == 0) ? w_addr : ADDR_W'($urandom);
      step();
    end
    idle(); step(); step();

    // Asynchronous reset in the middle of a read stream.
    for (int i = 0; i < DEPTH; i++) begin
      wr(i, $urandom | 32'h1, '1);
      step();
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      rdreq(i);
      step();
    end
    #2 arst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    #2 arst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rdreq(i);
      step();
    end
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      rdreq(i);
      step();
    end
    idle(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule : tb_iob_ram_2p_be_init
`default_nettype wire
